// File: rtl/omsp_spm_req_seq.sv
// Initiator-side sequencer for the SPM control data/key interface: READ_LAYOUT and WRITE_KEY commands.
// Optional post-write key readback check is enabled by defining SPM_REQ_KEY_READBACK_EN.
module omsp_spm_req_seq #(
    parameter int unsigned KEY_WORDS    = 4,
    parameter int unsigned KEY_IDX_SIZE = 2
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [15:0]             cmd_sel,
    input  logic                    cmd_sel_type,
    input  logic                    cmd_abort,
    input  logic                    key_word_valid,
    output logic                    key_word_ready,
    input  logic [15:0]             key_word,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [15:0]             rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             spm_data_select,
    output logic                    spm_data_select_type,
    output logic [15:0]             spm_key_select,
    output logic [2:0]              data_request,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
`ifdef SPM_REQ_KEY_READBACK_EN
    input  logic [0:KEY_WORDS*16-1] key_out,
`endif
    input  logic                    spm_data_select_valid,
    input  logic                    spm_key_select_valid,
    input  logic [15:0]             requested_data
);

    localparam int unsigned CNT_W = (KEY_IDX_SIZE > 3) ? KEY_IDX_SIZE : 3;
    localparam logic [CNT_W-1:0] CNT_RD_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_KEY_LAST = CNT_W'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_READ, S_KEY, S_VERIFY, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    op_q, op_nxt;
    logic                    to_err;

    logic                    cmd_ready_nxt, key_word_ready_nxt;
    logic                    rd_valid_nxt, rd_last_nxt, done_nxt, err_nxt;
    logic [15:0]             rd_data_nxt, key_in_nxt;
    logic [15:0]             spm_data_select_nxt, spm_key_select_nxt;
    logic                    spm_data_select_type_nxt;
    logic [2:0]              data_request_nxt;
    logic                    write_key_nxt;
    logic [KEY_IDX_SIZE-1:0] key_idx_nxt;

`ifdef SPM_REQ_KEY_READBACK_EN
    logic [15:0] shadow [KEY_WORDS];
    logic        key_mismatch;

    // Shadow copy of every word actually strobed into the SPM
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            for (int k = 0; k < int'(KEY_WORDS); k++) shadow[k] <= 16'h0000;
        end else if (write_key) begin
            shadow[key_idx] <= key_in;
        end
    end

    always_comb begin
        key_mismatch = 1'b0;
        for (int k = 0; k < int'(KEY_WORDS); k++) begin
            if (shadow[k] != key_out[k*16 +: 16]) key_mismatch = 1'b1;
        end
    end
`endif

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            op_q                 <= 1'b0;
            cmd_ready            <= 1'b0;
            key_word_ready       <= 1'b0;
            rd_valid             <= 1'b0;
            rd_data              <= 16'h0000;
            rd_last              <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            spm_data_select      <= 16'h0000;
            spm_data_select_type <= 1'b0;
            spm_key_select       <= 16'h0000;
            data_request         <= 3'd0;
            write_key            <= 1'b0;
            key_in               <= 16'h0000;
            key_idx              <= '0;
        end else begin
            state                <= state_nxt;
            cnt                  <= cnt_nxt;
            op_q                 <= op_nxt;
            cmd_ready            <= cmd_ready_nxt;
            key_word_ready       <= key_word_ready_nxt;
            rd_valid             <= rd_valid_nxt;
            rd_data              <= rd_data_nxt;
            rd_last              <= rd_last_nxt;
            done                 <= done_nxt;
            err                  <= err_nxt;
            spm_data_select      <= spm_data_select_nxt;
            spm_data_select_type <= spm_data_select_type_nxt;
            spm_key_select       <= spm_key_select_nxt;
            data_request         <= data_request_nxt;
            write_key            <= write_key_nxt;
            key_in               <= key_in_nxt;
            key_idx              <= key_idx_nxt;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nxt                = state;
        cnt_nxt                  = cnt;
        op_nxt                   = op_q;
        to_err                   = 1'b0;
        cmd_ready_nxt            = 1'b0;
        key_word_ready_nxt       = key_word_ready;
        rd_valid_nxt             = rd_valid;
        rd_data_nxt              = rd_data;
        rd_last_nxt              = rd_last;
        done_nxt                 = 1'b0;
        err_nxt                  = err;
        spm_data_select_nxt      = spm_data_select;
        spm_data_select_type_nxt = spm_data_select_type;
        spm_key_select_nxt       = spm_key_select;
        data_request_nxt         = 3'd0;
        write_key_nxt            = 1'b0;
        key_in_nxt               = key_in;
        key_idx_nxt              = key_idx;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt = S_CHECK;
                    op_nxt    = cmd_op;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    if (cmd_op) begin
                        spm_key_select_nxt = cmd_sel;
                    end else begin
                        spm_data_select_nxt      = cmd_sel;
                        spm_data_select_type_nxt = cmd_sel_type;
                    end
                end
            end
            S_CHECK: begin
                if (!op_q) begin
                    if (spm_data_select_valid) begin
                        state_nxt        = S_READ;
                        data_request_nxt = 3'd1;
                    end else begin
                        to_err = 1'b1;
                    end
                end else begin
                    if (spm_key_select_valid) begin
                        state_nxt          = S_KEY;
                        key_word_ready_nxt = 1'b1;
                    end else begin
                        to_err = 1'b1;
                    end
                end
            end
            S_READ: begin
                // rd_valid low means this cycle carries a live data_request
                if (!spm_data_select_valid) begin
                    to_err = 1'b1;
                end else if (!rd_valid) begin
                    rd_data_nxt  = requested_data;
                    rd_valid_nxt = 1'b1;
                    rd_last_nxt  = (cnt == CNT_RD_LAST);
                end else if (rd_ready) begin
                    rd_valid_nxt = 1'b0;
                    rd_last_nxt  = 1'b0;
                    if (rd_last) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt          = cnt + CNT_W'(1);
                        data_request_nxt = 3'(cnt + CNT_W'(2));
                    end
                end
            end
            S_KEY: begin
                if (!spm_key_select_valid) begin
                    to_err = 1'b1;
`ifdef SPM_REQ_KEY_READBACK_EN
                end else if (!key_word_ready) begin
                    // last write strobe is on the bus; compare once it has landed
                    state_nxt = S_VERIFY;
`endif
                end else if (key_word_valid) begin
                    write_key_nxt = 1'b1;
                    key_in_nxt    = key_word;
                    key_idx_nxt   = KEY_IDX_SIZE'(cnt);
                    if (cnt == CNT_KEY_LAST) begin
                        key_word_ready_nxt = 1'b0;
`ifndef SPM_REQ_KEY_READBACK_EN
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SPM_REQ_KEY_READBACK_EN
            S_VERIFY: begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
                err_nxt   = !spm_key_select_valid || key_mismatch;
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // SM missing or lost: finish with error, withdraw everything in flight
        if (to_err) begin
            state_nxt          = S_DONE;
            done_nxt           = 1'b1;
            err_nxt            = 1'b1;
            rd_valid_nxt       = 1'b0;
            rd_last_nxt        = 1'b0;
            key_word_ready_nxt = 1'b0;
            data_request_nxt   = 3'd0;
            write_key_nxt      = 1'b0;
        end

        // Abort wins over any handshake in the same cycle
        if (cmd_abort && (state != S_IDLE)) begin
            state_nxt          = S_IDLE;
            done_nxt           = 1'b0;
            rd_valid_nxt       = 1'b0;
            rd_last_nxt        = 1'b0;
            key_word_ready_nxt = 1'b0;
            data_request_nxt   = 3'd0;
            write_key_nxt      = 1'b0;
        end

        if (state_nxt == S_IDLE) begin
            cmd_ready_nxt            = 1'b1;
            spm_data_select_nxt      = 16'h0000;
            spm_data_select_type_nxt = 1'b0;
            spm_key_select_nxt       = 16'h0000;
        end
    end

endmodule

// File: tb/tb_omsp_spm_req_seq.sv
// Randomized self-checking bench for omsp_spm_req_seq against a transaction-level model.
module tb_omsp_spm_req_seq;

    localparam int unsigned KEY_WORDS    = 4;
    localparam int unsigned KEY_IDX_SIZE = 2;

    logic                    mclk = 1'b0;
    logic                    puc_rst_n;
    logic                    cmd_valid, cmd_ready, cmd_op, cmd_sel_type, cmd_abort;
    logic [15:0]             cmd_sel;
    logic                    key_word_valid, key_word_ready;
    logic [15:0]             key_word;
    logic                    rd_valid, rd_ready, rd_last, done, err;
    logic [15:0]             rd_data;
    logic [15:0]             spm_data_select, spm_key_select;
    logic                    spm_data_select_type;
    logic [2:0]              data_request;
    logic                    write_key;
    logic [15:0]             key_in;
    logic [KEY_IDX_SIZE-1:0] key_idx;
    logic                    spm_data_select_valid, spm_key_select_valid;
    logic [15:0]             requested_data;
`ifdef SPM_REQ_KEY_READBACK_EN
    logic [0:KEY_WORDS*16-1] key_out;
`endif

    logic [15:0] layout [4];
    logic [15:0] keyw [KEY_WORDS];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 mclk = ~mclk;

    // SPM control returns the selected SM's layout word for the current request
    assign requested_data = (data_request >= 3'd1 && data_request <= 3'd4) ?
                            layout[2'(data_request - 3'd1)] : 16'h0000;

    omsp_spm_req_seq #(.KEY_WORDS(KEY_WORDS), .KEY_IDX_SIZE(KEY_IDX_SIZE)) dut (
        .mclk                  (mclk),
        .puc_rst_n             (puc_rst_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_sel               (cmd_sel),
        .cmd_sel_type          (cmd_sel_type),
        .cmd_abort             (cmd_abort),
        .key_word_valid        (key_word_valid),
        .key_word_ready        (key_word_ready),
        .key_word              (key_word),
        .rd_valid              (rd_valid),
        .rd_ready              (rd_ready),
        .rd_data               (rd_data),
        .rd_last               (rd_last),
        .done                  (done),
        .err                   (err),
        .spm_data_select       (spm_data_select),
        .spm_data_select_type  (spm_data_select_type),
        .spm_key_select        (spm_key_select),
        .data_request          (data_request),
        .write_key             (write_key),
        .key_in                (key_in),
        .key_idx               (key_idx),
`ifdef SPM_REQ_KEY_READBACK_EN
        .key_out               (key_out),
`endif
        .spm_data_select_valid (spm_data_select_valid),
        .spm_key_select_valid  (spm_key_select_valid),
        .requested_data        (requested_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command: drive it, collect what the DUT emits, compare with the expected transaction
    task automatic do_cmd(input bit op, input logic [15:0] sel, input bit vflag,
                          input int abort_at, input int drop_at, input int stall_word,
                          input int rdy_pct, input int kv_pct, input int corrupt_idx);
        logic [16:0] got_rd[$];
        logic [2:0]  got_req[$];
        logic [17:0] got_wr[$];
        bit          got_done, got_err, kwr_seen, aborted, dropped, post_drop, held, timeout, rb_bad;
        logic [15:0] held_data;
        int          n_acc, words_sent, stall_left, cyc, exp_n;
        bit          exp_done, exp_err;

        got_done = 0; got_err = 0; kwr_seen = 0; aborted = 0; dropped = 0;
        post_drop = 0; held = 0; held_data = 16'h0; words_sent = 0;
        stall_left = (stall_word >= 0) ? 3 : 0;
`ifdef SPM_REQ_KEY_READBACK_EN
        for (int k = 0; k < int'(KEY_WORDS); k++)
            key_out[k*16 +: 16] = (k == corrupt_idx) ? keyw[k] + 16'd1 : keyw[k];
        rb_bad = op && (corrupt_idx >= 0);
`else
        rb_bad = 1'b0;
`endif
        spm_data_select_valid = vflag;
        spm_key_select_valid  = vflag;

        cyc = 0;
        while (!cmd_ready && cyc < 50) begin @(negedge mclk); cyc++; end
        check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_sel_type = 1'($urandom_range(1));
        @(negedge mclk);
        cmd_valid = 1'b0;
        check_val("err_clear", 32'(err), 32'd0);
        check_val("sel_drive", 32'(op ? spm_key_select : spm_data_select), 32'(sel));
        check_val("sel_other", 32'(op ? spm_data_select : spm_key_select), 32'd0);

        timeout = 1; cyc = 0;
        while (cyc < 400) begin
            n_acc = op ? words_sent : got_rd.size();
            cmd_abort = 0; rd_ready = 0; key_word_valid = 0; held = 0;
            if (!aborted && !dropped && abort_at >= 0 && n_acc == abort_at) begin
                cmd_abort = 1; aborted = 1;
                if (op && words_sent < int'(KEY_WORDS)) begin
                    key_word_valid = 1; key_word = keyw[words_sent];
                end
            end else if (!aborted && !dropped && drop_at >= 0 && n_acc == drop_at) begin
                spm_data_select_valid = 0; spm_key_select_valid = 0; dropped = 1;
            end else begin
                if (rd_valid && int'(got_rd.size()) == stall_word && stall_left > 0) begin
                    rd_ready = 0; stall_left--;
                end else begin
                    rd_ready = ($urandom_range(99) < rdy_pct);
                end
                if (rd_valid && rd_ready) got_rd.push_back({rd_last, rd_data});
                held = rd_valid && !rd_ready; held_data = rd_data;
                if (words_sent < int'(KEY_WORDS)) begin
                    key_word_valid = ($urandom_range(99) < kv_pct);
                    key_word = keyw[words_sent];
                end
                if (key_word_valid && key_word_ready) words_sent++;
            end

            @(negedge mclk); cyc++;
            if (key_word_ready) kwr_seen = 1;
            if (data_request != 3'd0) got_req.push_back(data_request);
            if (write_key) got_wr.push_back({key_idx, key_in});
            if (dropped && (rd_valid || write_key || key_word_ready || data_request != 3'd0)) post_drop = 1;
            if (held) begin
                check_val("rd_hold_valid", 32'(rd_valid), 32'd1);
                check_val("rd_hold_data", 32'(rd_data), 32'(held_data));
                check_val("rd_hold_req", 32'(data_request), 32'd0);
            end
            if (aborted) begin
                check_val("abort_ready", 32'(cmd_ready), 32'd1);
                check_val("abort_wkey", 32'(write_key), 32'd0);
                check_val("abort_done", 32'(done), 32'd0);
                check_val("abort_rdv", 32'(rd_valid), 32'd0);
                timeout = 0;
                break;
            end
            if (done) begin
                got_done = 1; got_err = err; timeout = 0;
                check_val("sel_hold", 32'(op ? spm_key_select : spm_data_select), 32'(sel));
                break;
            end
        end
        cmd_abort = 0; rd_ready = 0; key_word_valid = 0;
        check_val("finished", 32'(timeout), 32'd0);

        if (got_done) begin
            @(negedge mclk);
            check_val("done_pulse", 32'(done), 32'd0);
            check_val("ready_after", 32'(cmd_ready), 32'd1);
            check_val("sel_idle", 32'({spm_data_select, spm_key_select}), 32'd0);
        end

        exp_n    = !vflag ? 0 : (abort_at >= 0) ? abort_at : (drop_at >= 0) ? drop_at : 4;
        exp_done = !(vflag && abort_at >= 0);
        exp_err  = !vflag || (drop_at >= 0) || rb_bad;
        if (op) begin
            check_val("n_writes", 32'(got_wr.size()), 32'(exp_n));
            for (int i = 0; i < got_wr.size() && i < exp_n; i++)
                check_val("write", 32'(got_wr[i]), 32'({2'(i), keyw[i]}));
            check_val("n_reads_key", 32'(got_rd.size()), 32'd0);
        end else begin
            check_val("n_reads", 32'(got_rd.size()), 32'(exp_n));
            for (int i = 0; i < got_rd.size() && i < exp_n; i++)
                check_val("read", 32'(got_rd[i]), 32'({(i == 3) ? 1'b1 : 1'b0, layout[i]}));
            check_val("n_writes_rd", 32'(got_wr.size()), 32'd0);
            if (vflag && abort_at < 0 && drop_at < 0) begin
                check_val("n_req", 32'(got_req.size()), 32'd4);
                for (int i = 0; i < got_req.size() && i < 4; i++)
                    check_val("req", 32'(got_req[i]), 32'(i + 1));
            end
        end
        if (!vflag) begin
            check_val("no_req", 32'(got_req.size()), 32'd0);
            check_val("no_kwr", 32'(kwr_seen), 32'd0);
        end
        check_val("done_seen", 32'(got_done), 32'(exp_done));
        if (exp_done) check_val("err", 32'(got_err), 32'(exp_err));
        if (dropped) check_val("post_drop", 32'(post_drop), 32'd0);
    endtask

    initial begin
        puc_rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_sel = 0; cmd_sel_type = 0; cmd_abort = 0;
        key_word_valid = 0; key_word = 0; rd_ready = 0;
        spm_data_select_valid = 0; spm_key_select_valid = 0;
        layout[0] = 16'h8000; layout[1] = 16'h80FE; layout[2] = 16'h0200; layout[3] = 16'h02FE;
        keyw[0] = 16'h1111; keyw[1] = 16'h2222; keyw[2] = 16'h3333; keyw[3] = 16'h4444;
`ifdef SPM_REQ_KEY_READBACK_EN
        key_out = '0;
`endif
        repeat (2) @(negedge mclk);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_outs", 32'({done, err, rd_valid, write_key, key_word_ready, data_request}), 32'd0);
        check_val("rst_sel", 32'({spm_data_select, spm_key_select}), 32'd0);
        puc_rst_n = 1;
        @(negedge mclk);
        check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

        // op, sel, vflag, abort_at, drop_at, stall_word, rdy_pct, kv_pct, corrupt_idx
        do_cmd(1'b0, 16'h8000, 1'b1, -1, -1, -1, 100,   0, -1);
        do_cmd(1'b0, 16'h8000, 1'b1, -1, -1,  1, 100,   0, -1);
        do_cmd(1'b1, 16'h8000, 1'b1, -1, -1, -1, 100, 100, -1);
        do_cmd(1'b1, 16'h8000, 1'b0, -1, -1, -1, 100, 100, -1);
        do_cmd(1'b0, 16'h8000, 1'b0, -1, -1, -1, 100, 100, -1);
        do_cmd(1'b1, 16'h8000, 1'b1,  2, -1, -1, 100, 100, -1);
        do_cmd(1'b0, 16'h8000, 1'b1, -1, -1, -1, 100,   0, -1);
        do_cmd(1'b0, 16'h8000, 1'b1, -1,  1, -1, 100,   0, -1);
        do_cmd(1'b1, 16'h8000, 1'b1, -1,  2, -1, 100, 100, -1);
`ifdef SPM_REQ_KEY_READBACK_EN
        do_cmd(1'b1, 16'h8000, 1'b1, -1, -1, -1, 100, 100,  2);
        do_cmd(1'b1, 16'h8000, 1'b1, -1, -1, -1, 100, 100, -1);
`endif

        for (int t = 0; t < 30; t++) begin
            bit op, vf;
            int ab;
            op = 1'($urandom_range(1));
            vf = ($urandom_range(7) != 0);
            ab = (vf && $urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
            for (int i = 0; i < 4; i++) layout[i] = 16'($urandom);
            for (int i = 0; i < int'(KEY_WORDS); i++) keyw[i] = 16'($urandom);
            do_cmd(op, 16'($urandom), vf, ab, -1, -1,
                   int'($urandom_range(100, 25)), int'($urandom_range(100, 25)),
                   ($urandom_range(3) == 0) ? int'($urandom_range(KEY_WORDS - 1)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
